muldiv_ctrl: RTL and testbench

//  Sequencer between the CPU control unit and the shared multiply/divide resources.

---
 rtl/muldiv_ctrl_if.sv | 58 +++++
 rtl/muldiv_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Bundle of the CPU-side request/response signals and the shared
// multiply/divide unit signals seen by the muldiv_ctrl sequencer.
//
// Request handshake: a request transfers on a rising clk edge where
// op_valid & op_ready are both high. The requester holds op_valid, op_code,
// op_a and op_b stable until that edge. op_ready never depends on op_valid.
// rd_valid, div0 and err are single-cycle pulses with no back-pressure.
interface muldiv_ctrl_if;
  // CPU request side
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  // CPU response side
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        div0;
  logic        err;
  // Shared operand bus and unit control
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        unit_rst;
  // Multiplier
  logic        mult_start;
  logic        mult_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  // Divider
  logic        div_start;
  logic        div_done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  // Controller side
  modport slave (
    input  op_valid, op_code, op_a, op_b,
    output op_ready,
    output rd_valid, rd_data, div0, err,
    output unit_a, unit_b, unit_rst,
    output mult_start,
    input  mult_done, mult_hi, mult_lo,
    output div_start,
    input  div_done, div_hi, div_lo
  );

  // Environment side: CPU control unit plus the two arithmetic units
  modport master (
    output op_valid, op_code, op_a, op_b,
    input  op_ready,
    input  rd_valid, rd_data, div0, err,
    input  unit_a, unit_b, unit_rst,
    input  mult_start,
    output mult_done, mult_hi, mult_lo,
    input  div_start,
    output div_done, div_hi, div_lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the CPU control unit and the shared
// multiplier/divider. Latches operands, pulses the unit start line, waits
// for a rising done flag (or a timeout), and commits the unit result to the
// architectural HI/LO registers. MFHI/MFLO are served from HI/LO only while
// idle, which interlocks them against any in-flight operation.
module muldiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic         clk,
  input  logic         Reset,
  muldiv_ctrl_if.slave bus,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M_START = 3'd1,
    M_WAIT  = 3'd2,
    D_START = 3'd3,
    D_WAIT  = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MFHI = 2'b10;
  localparam logic [1:0] OP_MFLO = 2'b11;

  // Last counter value of a WAIT state; the edge leaving that cycle aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       cap_hi_q, cap_hi_d;
  logic [31:0]       cap_lo_q, cap_lo_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              div0_q, div0_d;
  logic              err_q, err_d;
  logic              unit_rst_q, unit_rst_d;
  logic              mdone_q;
  logic              ddone_q;
  logic              mult_rise;
  logic              div_rise;

  // Only a fresh rising done counts; a level left high by the previous
  // operation must not complete the current one.
  assign mult_rise = bus.mult_done & ~mdone_q;
  assign div_rise  = bus.div_done  & ~ddone_q;

  // Next-state and datapath decode; every target gets its hold value first.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_d        = a_q;
    b_d        = b_q;
    cap_hi_d   = cap_hi_q;
    cap_lo_d   = cap_lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    div0_d     = 1'b0;
    err_d      = 1'b0;
    unit_rst_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            OP_MULT: begin
              a_d     = bus.op_a;
              b_d     = bus.op_b;
              state_d = M_START;
            end
            OP_DIV: begin
              if (bus.op_b == 32'd0) begin
                // Rejected: HI/LO and the units are left untouched.
                div0_d = 1'b1;
              end else begin
                a_d     = bus.op_a;
                b_d     = bus.op_b;
                state_d = D_START;
              end
            end
            OP_MFHI: begin
              rd_valid_d = 1'b1;
              rd_data_d  = hi_q;
            end
            OP_MFLO: begin
              rd_valid_d = 1'b1;
              rd_data_d  = lo_q;
            end
            default: ;
          endcase
        end
      end

      M_START: begin
        cnt_d   = '0;
        state_d = M_WAIT;
      end

      M_WAIT: begin
        // Done is checked before the timeout so a completion on the last
        // allowed cycle still commits.
        if (mult_rise) begin
          cap_hi_d = bus.mult_hi;
          cap_lo_d = bus.mult_lo;
          state_d  = COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          err_d      = 1'b1;
          unit_rst_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      D_START: begin
        cnt_d   = '0;
        state_d = D_WAIT;
      end

      D_WAIT: begin
        if (div_rise) begin
          cap_hi_d = bus.div_hi;
          cap_lo_d = bus.div_lo;
          state_d  = COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          err_d      = 1'b1;
          unit_rst_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      COMMIT: begin
        hi_d    = cap_hi_q;
        lo_d    = cap_lo_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and timeout counter.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Architectural HI/LO, operand latches, captured result and output pulses.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cap_hi_q   <= '0;
      cap_lo_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      div0_q     <= 1'b0;
      err_q      <= 1'b0;
      unit_rst_q <= 1'b1;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cap_hi_q   <= cap_hi_d;
      cap_lo_q   <= cap_lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      div0_q     <= div0_d;
      err_q      <= err_d;
      unit_rst_q <= unit_rst_d;
    end
  end

  // Previous done levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      mdone_q <= 1'b0;
      ddone_q <= 1'b0;
    end else begin
      mdone_q <= bus.mult_done;
      ddone_q <= bus.div_done;
    end
  end

  assign bus.op_ready   = (state_q == IDLE);
  assign bus.mult_start = (state_q == M_START);
  assign bus.div_start  = (state_q == D_START);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.div0       = div0_q;
  assign bus.err        = err_q;
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;
  assign bus.unit_rst   = unit_rst_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: behavioural multiplier/divider models, a
// request driver, and a scoreboard that matches every rd_valid/div0/err
// pulse against expectations produced by a plain-arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int TIMEOUT = 40;
  localparam int W       = 34;

  localparam logic [1:0] K_RD   = 2'd0;
  localparam logic [1:0] K_DIV0 = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MFHI = 2'b10;
  localparam logic [1:0] OP_MFLO = 2'b11;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       Reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  logic [31:0]  ref_hi = '0;
  logic [31:0]  ref_lo = '0;
  int           exp_mstarts = 0;
  int           exp_dstarts = 0;
  int           act_mstarts = 0;
  int           act_dstarts = 0;
  int           last_start_cyc = 0;

  // unit behaviour for the next started operation
  int           cfg_hold = 0;
  int           cfg_lat  = 1;
  bit           cfg_hang = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- unit models ----------------
  // On start: keep the old done level for 'hold' cycles, drop it, then raise
  // it with the new result 'lat' cycles later (never, when hung).
  initial begin : mult_unit
    int     cnt;
    int     lat;
    bit     pend;
    bit     hang;
    longint p;
    bus.mult_done = 1'b0;
    bus.mult_hi   = '0;
    bus.mult_lo   = '0;
    cnt = 0; lat = 0; pend = 1'b0; hang = 1'b0; p = 0;
    forever begin
      @(negedge clk);
      if (bus.mult_start) begin
        p    = longint'($signed(bus.unit_a)) * longint'($signed(bus.unit_b));
        lat  = cfg_lat;
        hang = cfg_hang;
        cnt  = cfg_hold + cfg_lat;
        pend = 1'b1;
        if (cfg_hold == 0) bus.mult_done = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == lat) bus.mult_done = 1'b0;
        if (cnt == 0) begin
          pend = 1'b0;
          if (!hang) begin
            bus.mult_hi   = p[63:32];
            bus.mult_lo   = p[31:0];
            bus.mult_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : div_unit
    int     cnt;
    int     lat;
    bit     pend;
    bit     hang;
    longint q;
    longint r;
    bus.div_done = 1'b0;
    bus.div_hi   = '0;
    bus.div_lo   = '0;
    cnt = 0; lat = 0; pend = 1'b0; hang = 1'b0; q = 0; r = 0;
    forever begin
      @(negedge clk);
      if (bus.div_start) begin
        if (bus.unit_b != 32'd0) begin
          q = longint'($signed(bus.unit_a)) / longint'($signed(bus.unit_b));
          r = longint'($signed(bus.unit_a)) % longint'($signed(bus.unit_b));
        end else begin
          q = 0;
          r = 0;
        end
        lat  = cfg_lat;
        hang = cfg_hang;
        cnt  = cfg_hold + cfg_lat;
        pend = 1'b1;
        if (cfg_hold == 0) bus.div_done = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == lat) bus.div_done = 1'b0;
        if (cnt == 0) begin
          pend = 1'b0;
          if (!hang) begin
            bus.div_hi   = r[31:0];
            bus.div_lo   = q[31:0];
            bus.div_done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] act;
    logic [W-1:0] req;
    int           ecyc;
    int           npulse;
    forever begin
      @(negedge clk);
      if (bus.mult_start) begin act_mstarts++; last_start_cyc = cyc; end
      if (bus.div_start)  begin act_dstarts++; last_start_cyc = cyc; end
      npulse = int'(bus.rd_valid) + int'(bus.div0) + int'(bus.err);
      if (npulse > 0) begin
        if (bus.rd_valid)  act = {K_RD, bus.rd_data};
        else if (bus.div0) act = {K_DIV0, 32'h0};
        else               act = {K_ERR, 32'h0};
        if (npulse > 1) begin
          n_checks++; n_fail++;
          $display("FAIL pulse_overlap: got %0d simultaneous pulses, required 1 (cycle %0d)", npulse, cyc);
        end
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pulse: got 0x%0h, required no pulse (cycle %0d)", act, cyc);
        end else begin
          req  = exp_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          check("pulse_value", 64'(act), 64'(req));
          if (ecyc >= 0) begin
            check("pulse_cycle", 64'(cyc), 64'(ecyc));
          end else begin
            check("err_cycle", 64'(cyc), 64'(last_start_cyc + TIMEOUT + 1));
            check("err_unit_rst", 64'(bus.unit_rst), 64'd1);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int lat, input bit hang);
    int     waited;
    longint p;
    longint q;
    longint r;
    bit     fails;
    waited = 0;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    while (!bus.op_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.op_ready) begin
      n_checks++; n_fail++;
      $display("FAIL op_accept_timeout: op_ready=0 after %0d cycles, required 1", waited);
      bus.op_valid = 1'b0;
      return;
    end
    cfg_hold = hold;
    cfg_lat  = lat;
    cfg_hang = hang;
    fails = hang || (hold + lat > TIMEOUT);
    case (code)
      OP_MULT: begin
        exp_mstarts++;
        if (fails) begin
          exp_q.push_back({K_ERR, 32'h0}); exp_cyc_q.push_back(-1);
        end else begin
          p = longint'($signed(a)) * longint'($signed(b));
          ref_hi = p[63:32];
          ref_lo = p[31:0];
        end
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          exp_q.push_back({K_DIV0, 32'h0}); exp_cyc_q.push_back(cyc + 1);
        end else begin
          exp_dstarts++;
          if (fails) begin
            exp_q.push_back({K_ERR, 32'h0}); exp_cyc_q.push_back(-1);
          end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            ref_hi = r[31:0];
            ref_lo = q[31:0];
          end
        end
      end
      OP_MFHI: begin
        exp_q.push_back({K_RD, ref_hi}); exp_cyc_q.push_back(cyc + 1);
      end
      default: begin
        exp_q.push_back({K_RD, ref_lo}); exp_cyc_q.push_back(cyc + 1);
      end
    endcase
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [1:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    int          waited;

    Reset        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    bus.op_a     = '0;
    bus.op_b     = '0;
    idle(3);
    check("rst_op_ready", 64'(bus.op_ready), 64'd1);
    check("rst_unit_rst", 64'(bus.unit_rst), 64'd1);
    check("rst_unit_a",   64'(bus.unit_a),   64'd0);
    check("rst_unit_b",   64'(bus.unit_b),   64'd0);
    check("rst_rd_data",  64'(bus.rd_data),  64'd0);
    check("rst_pulses",   64'({bus.rd_valid, bus.div0, bus.err, bus.mult_start, bus.div_start}), 64'd0);
    Reset = 1'b1;
    idle(2);
    check("post_rst_unit_rst", 64'(bus.unit_rst), 64'd0);

    // MULT 7 * -3, then read both halves
    send_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, 5, 1'b0);
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);

    // DIV 100 / 7, with the multiplier's done still high from before
    send_op(OP_DIV, 32'd100, 32'd7, 0, 6, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);

    // HI=5, LO=9, then a divide by zero must leave them alone
    send_op(OP_DIV, 32'd95, 32'd10, 0, 3, 1'b0);
    send_op(OP_DIV, 32'd1234, 32'd0, 0, 3, 1'b0);
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);

    // MULT 0x10000 * 0x10000 followed at once by MFHI: interlocked
    send_op(OP_MULT, 32'h0001_0000, 32'h0001_0000, 0, 4, 1'b0);
    check("interlock_op_ready", 64'(bus.op_ready), 64'd0);
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);

    // Stale done held high across the next start must be ignored
    send_op(OP_MULT, 32'd11, 32'd13, 3, 4, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);

    // Hung multiplier: timeout abort, HI/LO unchanged
    send_op(OP_MULT, 32'd99, 32'd99, 0, 1, 1'b1);
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);

    // Done on the last allowed WAIT cycle wins; one cycle later is a timeout
    send_op(OP_MULT, 32'd3, 32'd5, 0, TIMEOUT, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);
    send_op(OP_DIV, 32'd77, 32'd2, 0, TIMEOUT + 1, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);

    // Reset while in D_WAIT: aborts, clears HI/LO, late done ignored
    send_op(OP_DIV, 32'd1000, 32'd3, 0, 10, 1'b0);
    idle(3);
    Reset = 1'b0;
    @(negedge clk);
    check("midrst_op_ready", 64'(bus.op_ready), 64'd1);
    check("midrst_unit_a",   64'(bus.unit_a),   64'd0);
    check("midrst_unit_b",   64'(bus.unit_b),   64'd0);
    check("midrst_rd_data",  64'(bus.rd_data),  64'd0);
    check("midrst_unit_rst", 64'(bus.unit_rst), 64'd1);
    Reset  = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    idle(15);
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      code = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
      if (code == OP_DIV && $urandom_range(0, 5) == 0) b = '0;
      send_op(code, a, b, $urandom_range(0, 3), $urandom_range(1, 12),
              ($urandom_range(0, 11) == 0));
      idle($urandom_range(0, 2));
    end
    send_op(OP_MFHI, '0, '0, 0, 1, 1'b0);
    send_op(OP_MFLO, '0, '0, 0, 1, 1'b0);

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("mult_start_count", 64'(act_mstarts), 64'(exp_mstarts));
    check("div_start_count",  64'(act_dstarts), 64'(exp_dstarts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
